// File: rtl/mod_mixcolumns_iter.sv
// Iterative AES MixColumns / InvMixColumns stage with bypass for the final round.
// Transforms COLS_PER_CYCLE columns per clock and hands the full state over a
// valid/ready interface. state_out only ever changes as a whole block.
module mod_mixcolumns_iter #(
  parameter int COLS_PER_CYCLE = 1,
  parameter bit INV_EN         = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             mode,
  input  logic             bypass,
  input  logic [15:0][7:0] state_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [15:0][7:0] state_out,
  output logic             done,
  output logic             busy
);

  generate
    if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : g_bad_cols
      $error("mod_mixcolumns_iter: COLS_PER_CYCLE must be 1, 2 or 4");
    end
  endgenerate

  // Counter advance per cycle; with four columns per cycle the first CALC cycle
  // is also the last, so the wrap to zero is harmless.
  localparam logic [1:0] STEP     = 2'(COLS_PER_CYCLE % 4);
  localparam logic [1:0] LAST_CNT = 2'(4 - COLS_PER_CYCLE);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

  state_e           state_q, state_d;
  logic [1:0]       cnt_q, cnt_d;
  logic             out_valid_q, out_valid_d;
  logic             done_q, done_d;
  logic [15:0][7:0] state_out_q, state_out_d;
  logic [15:0][7:0] work_q;
  logic [15:0][7:0] buf_q, buf_d;
  logic             bypass_q;
  logic             inv_sel;
  logic             accept;

  // Multiply by x in GF(2^8) modulo x^8+x^4+x^3+x+1.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // One column through forward, inverse or bypass; coefficients from xtime chains.
  function automatic logic [3:0][7:0] col_xform(input logic [3:0][7:0] a,
                                                input logic inv, input logic byp);
    logic [3:0][7:0] x2, x4, x8, m9, mb, md, me, b;
    for (int i = 0; i < 4; i++) begin
      x2[i] = xtime(a[i]);
      x4[i] = xtime(x2[i]);
      x8[i] = xtime(x4[i]);
      m9[i] = x8[i] ^ a[i];
      mb[i] = x8[i] ^ x2[i] ^ a[i];
      md[i] = x8[i] ^ x4[i] ^ a[i];
      me[i] = x8[i] ^ x4[i] ^ x2[i];
    end
    for (int r = 0; r < 4; r++) begin
      if (byp) begin
        b[r] = a[r];
      end else if (inv) begin
        b[r] = me[r] ^ mb[(r + 1) % 4] ^ md[(r + 2) % 4] ^ m9[(r + 3) % 4];
      end else begin
        b[r] = x2[r] ^ x2[(r + 1) % 4] ^ a[(r + 1) % 4] ^ a[(r + 2) % 4] ^ a[(r + 3) % 4];
      end
    end
    return b;
  endfunction

  assign in_ready  = (state_q == IDLE) || (state_q == DONE && out_ready);
  assign accept    = in_valid && in_ready;
  assign busy      = (state_q != IDLE);
  assign out_valid = out_valid_q;
  assign done      = done_q;
  assign state_out = state_out_q;

  // Mode is only kept when the inverse datapath exists.
  generate
    if (INV_EN) begin : g_inv
      logic mode_q;
      // Capture the direction of the accepted block.
      always_ff @(posedge clk) begin
        if (accept) mode_q <= mode;
      end
      assign inv_sel = mode_q;
    end else begin : g_fwd_only
      logic unused_mode;
      assign unused_mode = mode;
      assign inv_sel     = 1'b0;
    end
  endgenerate

  // Transform the columns selected by the counter into the result buffer.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path infers a latch.
    buf_d = buf_q;
    if (state_q == CALC) begin
      for (int k = 0; k < COLS_PER_CYCLE; k++) begin
        buf_d[4 * int'(cnt_q + 2'(k)) +: 4] =
          col_xform(work_q[4 * int'(cnt_q + 2'(k)) +: 4], inv_sel, bypass_q);
      end
    end
  end

  // Next-state and output-register logic for IDLE -> CALC -> DONE.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q;
    done_d      = 1'b0;
    state_out_d = state_out_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = CALC;
          cnt_d   = 2'd0;
        end
      end
      CALC: begin
        cnt_d = cnt_q + STEP;
        if (cnt_q == LAST_CNT) begin
          state_d     = DONE;
          out_valid_d = 1'b1;
          done_d      = 1'b1;
          state_out_d = buf_d;
        end
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          if (accept) begin
            state_d = CALC;
            cnt_d   = 2'd0;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Control and visible output registers; reset drops any in-flight block.
  always_ff @(posedge clk or negedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (!reset) begin
      state_q     <= IDLE;
      cnt_q       <= 2'd0;
      out_valid_q <= 1'b0;
      done_q      <= 1'b0;
      state_out_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      done_q      <= done_d;
      state_out_q <= state_out_d;
    end
  end

  // Working copy of the accepted block and the partial result buffer.
  always_ff @(posedge clk) begin
    // NOTE: datapath storage is left unreset; the FSM never exposes it before it is written.
    if (accept) begin
      work_q   <= state_in;
      bypass_q <= bypass;
    end
    buf_q <= buf_d;
  end

endmodule

// File: tb/tb_mod_mixcolumns_iter.sv
// Self-checking bench: four instances (1, 2, 4 columns per cycle with inverse,
// and 1 column forward-only) compared every cycle against a transaction-level
// model built on generic GF(2^8) multiplication.
module tb_mod_mixcolumns_iter;

  localparam int ND = 4;

  logic                      clk = 1'b0;
  logic                      reset;
  logic [ND-1:0]             in_valid, in_ready, mode, bypass;
  logic [ND-1:0]             out_valid, out_ready, done, busy;
  logic [ND-1:0][15:0][7:0]  state_in, state_out;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  generate
    for (genvar g = 0; g < ND; g++) begin : g_dut
      mod_mixcolumns_iter #(
        .COLS_PER_CYCLE(g == 2 ? 4 : (g == 1 ? 2 : 1)),
        .INV_EN        (g == 3 ? 1'b0 : 1'b1)
      ) u_dut (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid[g]),
        .in_ready (in_ready[g]),
        .mode     (mode[g]),
        .bypass   (bypass[g]),
        .state_in (state_in[g]),
        .out_valid(out_valid[g]),
        .out_ready(out_ready[g]),
        .state_out(state_out[g]),
        .done     (done[g]),
        .busy     (busy[g])
      );
    end
  endgenerate

  function automatic int ncyc_of(input int d);
    return (d == 2) ? 1 : ((d == 1) ? 2 : 4);
  endfunction

  function automatic bit inv_of(input int d);
    return (d != 3);
  endfunction

  // Generic shift-and-add GF(2^8) multiply.
  function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
    logic [7:0] a, b, p;
    a = a_in; b = b_in; p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
      b = b >> 1;
    end
    return p;
  endfunction

  // Whole-state reference: circulant matrix product per column.
  function automatic logic [15:0][7:0] ref_block(input logic [15:0][7:0] st, input bit md,
                                                 input bit bp, input bit inv_en);
    logic [15:0][7:0] o;
    logic [7:0] coef [4];
    logic [7:0] acc;
    if (bp) return st;
    if (md && inv_en) begin
      coef[0] = 8'h0e; coef[1] = 8'h0b; coef[2] = 8'h0d; coef[3] = 8'h09;
    end else begin
      coef[0] = 8'h02; coef[1] = 8'h03; coef[2] = 8'h01; coef[3] = 8'h01;
    end
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        acc = 8'h00;
        for (int j = 0; j < 4; j++) acc = acc ^ gmul(coef[(j - r + 4) % 4], st[4*c + j]);
        o[4*c + r] = acc;
      end
    end
    return o;
  endfunction

  // Column words with the first byte in the top bits.
  function automatic logic [15:0][7:0] mk_state(input logic [31:0] c0, input logic [31:0] c1,
                                                input logic [31:0] c2, input logic [31:0] c3);
    logic [31:0] w [4];
    logic [15:0][7:0] s;
    w[0] = c0; w[1] = c1; w[2] = c2; w[3] = c3;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) s[4*c + r] = w[c][31 - 8*r -: 8];
    return s;
  endfunction

  function automatic logic [15:0][7:0] rand_state();
    return mk_state($urandom, $urandom, $urandom, $urandom);
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  int               calc_left [ND];
  bit               m_ov      [ND];
  bit               m_done    [ND];
  logic [15:0][7:0] m_out     [ND];
  logic [15:0][7:0] m_pend    [ND];
  int               done_seen [ND];
  bit               rdy_m, acc_m;

  initial begin
    for (int d = 0; d < ND; d++) begin
      calc_left[d] = 0; m_ov[d] = 0; m_done[d] = 0; m_out[d] = '0; m_pend[d] = '0;
      done_seen[d] = 0;
    end
    forever begin
      @(posedge clk or negedge reset);
      for (int d = 0; d < ND; d++) begin
        if (!reset) begin
          calc_left[d] = 0; m_ov[d] = 0; m_done[d] = 0; m_out[d] = '0;
        end else begin
          rdy_m = (calc_left[d] == 0) && (!m_ov[d] || out_ready[d]);
          acc_m = in_valid[d] && rdy_m;
          m_done[d] = 0;
          if (m_ov[d] && out_ready[d]) m_ov[d] = 0;
          if (calc_left[d] > 0) begin
            calc_left[d]--;
            if (calc_left[d] == 0) begin
              m_ov[d] = 1; m_done[d] = 1; m_out[d] = m_pend[d];
            end
          end
          if (acc_m) begin
            m_pend[d]    = ref_block(state_in[d], mode[d], bypass[d], inv_of(d));
            calc_left[d] = ncyc_of(d);
          end
        end
      end
    end
  end

  // Per-cycle comparison on the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      if (reset) begin
        for (int d = 0; d < ND; d++) begin
          check($sformatf("d%0d out_valid", d), 128'(out_valid[d]), 128'(m_ov[d]));
          check($sformatf("d%0d done", d), 128'(done[d]), 128'(m_done[d]));
          check($sformatf("d%0d busy", d), 128'(busy[d]), 128'(calc_left[d] > 0 || m_ov[d]));
          check($sformatf("d%0d in_ready", d), 128'(in_ready[d]),
                128'((calc_left[d] == 0) && (!m_ov[d] || out_ready[d])));
          check($sformatf("d%0d state_out", d), state_out[d], m_out[d]);
          if (done[d]) done_seen[d]++;
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL global timeout");
    $fatal(1, "timeout");
  end

  // ---------------- stimulus ----------------
  logic [15:0][7:0] fwd_in, fwd_out, inv_in, inv_out, byp_in;

  task automatic next_drive();
    @(negedge clk);
    #1;
  endtask

  // One block from idle with out_ready high; returns result and latency.
  task automatic run_block(input int d, input logic [15:0][7:0] st, input bit md, input bit bp,
                           output logic [15:0][7:0] res, output int lat);
    next_drive();
    in_valid[d] = 1'b1; state_in[d] = st; mode[d] = md; bypass[d] = bp; out_ready[d] = 1'b1;
    @(posedge clk);
    #1;
    in_valid[d] = 1'b0; state_in[d] = rand_state(); mode[d] = ~md; bypass[d] = ~bp;
    lat = -1;
    res = '0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk);
      #1;
      if (out_valid[d]) begin
        lat = i; res = state_out[d];
        break;
      end
    end
    bypass[d] = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) next_drive();
  endtask

  logic [15:0][7:0] res;
  int lat, d0, nb;

  initial begin
    fwd_in  = mk_state(32'hdb135345, 32'hf20a225c, 32'h01010101, 32'hc6c6c6c6);
    fwd_out = mk_state(32'h8e4da1bc, 32'h9fdc589d, 32'h01010101, 32'hc6c6c6c6);
    inv_in  = mk_state(32'h8e4da1bc, 32'h9fdc589d, 32'hd5d5d7d6, 32'h4d7ebdf8);
    inv_out = mk_state(32'hdb135345, 32'hf20a225c, 32'hd4d4d4d5, 32'h2d26314c);
    for (int i = 0; i < 16; i++) byp_in[i] = 8'(i * 17);

    in_valid = '0; out_ready = '0; mode = '0; bypass = '0; state_in = '0;
    reset = 1'b0;

    // Pin the model on the known vectors.
    check("model fwd", ref_block(fwd_in, 1'b0, 1'b0, 1'b1), fwd_out);
    check("model inv", ref_block(inv_in, 1'b1, 1'b0, 1'b1), inv_out);
    check("model byp", ref_block(byp_in, 1'b1, 1'b1, 1'b1), byp_in);

    #1;
    for (int d = 0; d < ND; d++) begin
      check($sformatf("d%0d reset out_valid", d), 128'(out_valid[d]), 128'(0));
      check($sformatf("d%0d reset done", d), 128'(done[d]), 128'(0));
      check($sformatf("d%0d reset busy", d), 128'(busy[d]), 128'(0));
      check($sformatf("d%0d reset state_out", d), state_out[d], 128'(0));
    end
    repeat (3) @(negedge clk);
    #1 reset = 1'b1;
    idle_cycles(2);

    for (int d = 0; d < ND; d++) begin
      // Forward known vector.
      run_block(d, fwd_in, 1'b0, 1'b0, res, lat);
      check($sformatf("d%0d fwd latency", d), 128'(lat), 128'(ncyc_of(d)));
      check($sformatf("d%0d fwd result", d), res, fwd_out);
      idle_cycles(2);

      // Inverse known vector (forward-only instance must ignore mode).
      run_block(d, inv_in, 1'b1, 1'b0, res, lat);
      check($sformatf("d%0d inv latency", d), 128'(lat), 128'(ncyc_of(d)));
      if (inv_of(d)) check($sformatf("d%0d inv result", d), res, inv_out);
      else           check($sformatf("d%0d mode ignored", d), res, ref_block(inv_in, 1'b0, 1'b0, 1'b1));
      idle_cycles(2);

      // Bypass, then stall downstream for 10 cycles while the input wiggles.
      next_drive();
      in_valid[d] = 1'b1; state_in[d] = byp_in; bypass[d] = 1'b1; mode[d] = 1'b0; out_ready[d] = 1'b0;
      @(posedge clk);
      #1 in_valid[d] = 1'b0;
      lat = -1;
      for (int i = 1; i <= 20; i++) begin
        if (out_valid[d]) break;
        @(posedge clk);
        #1 lat = i;
      end
      check($sformatf("d%0d byp latency", d), 128'(lat), 128'(ncyc_of(d)));
      for (int i = 0; i < 10; i++) begin
        next_drive();
        in_valid[d] = 1'b1; state_in[d] = rand_state(); bypass[d] = $urandom_range(0, 1) == 1;
        #2;
        check($sformatf("d%0d stall out_valid", d), 128'(out_valid[d]), 128'(1));
        check($sformatf("d%0d stall state_out", d), state_out[d], byp_in);
        check($sformatf("d%0d stall in_ready", d), 128'(in_ready[d]), 128'(0));
      end
      next_drive();
      in_valid[d] = 1'b0; bypass[d] = 1'b0; out_ready[d] = 1'b1;
      idle_cycles(3);

      // Back-to-back with in_valid held: five results in 5*(NCYC+1) edges.
      nb = 5 * (ncyc_of(d) + 1);
      next_drive();
      d0 = done_seen[d];
      in_valid[d] = 1'b1; out_ready[d] = 1'b1; state_in[d] = rand_state(); mode[d] = 1'b0;
      for (int i = 0; i <= nb; i++) begin
        @(posedge clk);
        #1;
        state_in[d] = rand_state(); mode[d] = $urandom_range(0, 1) == 1;
      end
      next_drive();
      check($sformatf("d%0d b2b done pulses", d), 128'(done_seen[d] - d0), 128'(5));
      in_valid[d] = 1'b0;
      idle_cycles(8);
    end

    // Randomised traffic on all instances at once.
    for (int i = 0; i < 400; i++) begin
      next_drive();
      for (int d = 0; d < ND; d++) begin
        in_valid[d]  = ($urandom % 4) != 0;
        out_ready[d] = ($urandom % 3) != 0;
        state_in[d]  = rand_state();
        mode[d]      = $urandom_range(0, 1) == 1;
        bypass[d]    = ($urandom % 8) == 0;
      end
    end
    next_drive();
    in_valid = '0; out_ready = '1; bypass = '0;
    idle_cycles(8);

    // Reset in the middle of CALC on the one-column instance.
    next_drive();
    in_valid[0] = 1'b1; state_in[0] = fwd_in; mode[0] = 1'b0; out_ready[0] = 1'b1;
    @(posedge clk);
    #1 in_valid[0] = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #3 reset = 1'b0;
    #1;
    check("rst async out_valid", 128'(out_valid[0]), 128'(0));
    check("rst async done", 128'(done[0]), 128'(0));
    check("rst async busy", 128'(busy[0]), 128'(0));
    check("rst async state_out", state_out[0], 128'(0));
    next_drive();
    reset = 1'b1;
    #2 check("rst in_ready after release", 128'(in_ready[0]), 128'(1));
    for (int i = 0; i < 10; i++) begin
      next_drive();
      check("rst dropped block", 128'(out_valid[0]), 128'(0));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
